// File: rtl/my_multiplier_16.sv
// rtl/my_multiplier_16.sv - sequential 16x16 shift-and-add multiplier on a single 16-bit adder
// Exports low half of the product plus an overflow flag for a nonzero high half.

module my_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    assign sum = a + b;
endmodule

module my_multiplier_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        overflow
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_m;
    logic [15:0] r_p_hi;
    logic [15:0] r_p_lo;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_out;
    logic        r_overflow;

    logic [15:0] w_sum;
    logic        w_c16;
    logic        w_acc_c;
    logic [15:0] w_acc_hi;
    logic [15:0] w_next_hi;
    logic [15:0] w_next_lo;

    my_adder_16 u_adder (
        .a   (r_p_hi),
        .b   (r_m),
        .sum (w_sum)
    );

    // The adder has no carry-out; recover it from the operand and sum MSBs.
    assign w_c16     = (r_p_hi[15] & r_m[15]) | ((r_p_hi[15] | r_m[15]) & ~w_sum[15]);
    assign w_acc_c   = r_p_lo[0] ? w_c16 : 1'b0;
    assign w_acc_hi  = r_p_lo[0] ? w_sum : r_p_hi;
    assign w_next_hi = {w_acc_c, w_acc_hi[15:1]};
    assign w_next_lo = {w_acc_hi[0], r_p_lo[15:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_m        <= 16'h0000;
            r_p_hi     <= 16'h0000;
            r_p_lo     <= 16'h0000;
            r_cnt      <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_out      <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= a;
                        r_p_hi  <= 16'h0000;
                        r_p_lo  <= b;
                        r_cnt   <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_p_hi <= w_next_hi;
                    r_p_lo <= w_next_lo;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd15) begin
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_out      <= w_next_lo;
                        r_overflow <= |w_next_hi;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign out      = r_out;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_my_multiplier_16.sv
// tb/tb_my_multiplier_16.sv - directed self-checking bench for my_multiplier_16

module tb_my_multiplier_16;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        overflow;

    int checks;
    int failures;

    my_multiplier_16 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start pulse, then watches 40 cycles recording when done shows up.
    task automatic run_mul(input logic [15:0] ia, input logic [15:0] ib,
                           output logic [15:0] r_out, output logic r_ov,
                           output int done_cyc, output int busy_cnt,
                           output int done_cnt, output int both_cnt);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; both_cnt = 0;
        r_out = 16'hXXXX; r_ov = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && done) both_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = k;
                    r_out = out;
                    r_ov = overflow;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b out=%h ov=%b expected 0 0 0000 0",
                     busy, done, out, overflow);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] o; logic v; int dc, bc, nc, bt;
        run_mul(16'd3, 16'd5, o, v, dc, bc, nc, bt);
        checks++;
        if (dc !== 17) begin failures++; $display("FAIL basic_latency: done at %0d expected 17", dc); end
        checks++;
        if (bc !== 16) begin failures++; $display("FAIL basic_busy_len: %0d expected 16", bc); end
        checks++;
        if (o !== 16'h000F || v !== 1'b0) begin failures++; $display("FAIL basic_3x5: out=%h ov=%b expected 000f 0", o, v); end
        checks++;
        if (nc !== 1 || bt !== 0) begin failures++; $display("FAIL basic_done_pulse: dones=%0d overlap=%0d expected 1 0", nc, bt); end
        checks++;
        if (out !== 16'h000F) begin failures++; $display("FAIL basic_hold: out=%h expected 000f", out); end
    endtask

    task automatic test_products;
        logic [15:0] o; logic v; int dc, bc, nc, bt;
        run_mul(16'h00FF, 16'h0101, o, v, dc, bc, nc, bt);
        checks++;
        if (o !== 16'hFFFF || v !== 1'b0 || dc !== 17) begin failures++; $display("FAIL prod_ff_101: out=%h ov=%b cyc=%0d expected ffff 0 17", o, v, dc); end
        run_mul(16'h4000, 16'h0002, o, v, dc, bc, nc, bt);
        checks++;
        if (o !== 16'h8000 || v !== 1'b0) begin failures++; $display("FAIL prod_4000_2: out=%h ov=%b expected 8000 0", o, v); end
        run_mul(16'h0100, 16'h0100, o, v, dc, bc, nc, bt);
        checks++;
        if (o !== 16'h0000 || v !== 1'b1) begin failures++; $display("FAIL prod_100_100: out=%h ov=%b expected 0000 1", o, v); end
        run_mul(16'hFFFF, 16'hFFFF, o, v, dc, bc, nc, bt);
        checks++;
        if (o !== 16'h0001 || v !== 1'b1) begin failures++; $display("FAIL prod_ffff_ffff: out=%h ov=%b expected 0001 1", o, v); end
        run_mul(16'h8001, 16'h0003, o, v, dc, bc, nc, bt);
        checks++;
        if (o !== 16'h8003 || v !== 1'b1) begin failures++; $display("FAIL prod_8001_3: out=%h ov=%b expected 8003 1", o, v); end
    endtask

    task automatic test_ignore_start;
        int dc, nc;
        logic [15:0] o;
        @(negedge clk);
        a = 16'd7; b = 16'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dc = 0; nc = 0; o = 16'hXXXX;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                nc++;
                if (dc == 0) begin dc = k; o = out; end
            end
            if (k == 5)  begin a = 16'd9; b = 16'd9; start = 1'b1; end
            if (k == 6)  start = 1'b0;
            if (k == 17) begin a = 16'd9; b = 16'd9; start = 1'b1; end
            if (k == 18) start = 1'b0;
        end
        checks++;
        if (o !== 16'h002A || dc !== 17) begin failures++; $display("FAIL ignore_result: out=%h cyc=%0d expected 002a 17", o, dc); end
        checks++;
        if (nc !== 1) begin failures++; $display("FAIL ignore_one_done: dones=%0d expected 1", nc); end
        checks++;
        if (busy !== 1'b0 || out !== 16'h002A) begin failures++; $display("FAIL ignore_idle: busy=%b out=%h expected 0 002a", busy, out); end
    endtask

    task automatic test_abort;
        logic [15:0] o; logic v; int dc, bc, nc, bt;
        int seen_done;
        @(negedge clk);
        a = 16'h1234; b = 16'h0010; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (int k = 1; k < 8; k++) begin
            if (k > 1) @(negedge clk);
            if (done) seen_done++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: busy=%b done=%b out=%h ov=%b expected 0 0 0000 0", busy, done, out, overflow);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        reset = 1'b0;
        checks++;
        if (seen_done !== 0) begin failures++; $display("FAIL abort_no_done: dones=%0d expected 0", seen_done); end
        run_mul(16'd2, 16'd0, o, v, dc, bc, nc, bt);
        checks++;
        if (o !== 16'h0000 || v !== 1'b0 || dc !== 17) begin failures++; $display("FAIL abort_after: out=%h ov=%b cyc=%0d expected 0000 0 17", o, v, dc); end
    endtask

    task automatic test_back_to_back;
        int d1, d2, nc, both;
        logic [15:0] o1, o2;
        logic v1, v2;
        @(negedge clk);
        a = 16'd10; b = 16'd10; start = 1'b1;
        d1 = 0; d2 = 0; nc = 0; both = 0;
        o1 = 16'hXXXX; o2 = 16'hXXXX; v1 = 1'bx; v2 = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy && done) both++;
            if (done) begin
                nc++;
                if (nc == 1) begin d1 = k; o1 = out; v1 = overflow; end
                if (nc == 2) begin d2 = k; o2 = out; v2 = overflow; end
            end
        end
        start = 1'b0;
        checks++;
        if (nc !== 2 || (d2 - d1) !== 18) begin failures++; $display("FAIL b2b_spacing: dones=%0d gap=%0d expected 2 18", nc, d2 - d1); end
        checks++;
        if (o1 !== 16'h0064 || o2 !== 16'h0064 || v1 !== 1'b0 || v2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: out=%h,%h ov=%b,%b expected 0064 0", o1, o2, v1, v2);
        end
        checks++;
        if (both !== 0) begin failures++; $display("FAIL b2b_overlap: %0d expected 0", both); end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_products();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/my_multiplier_16.md
# my_multiplier_16

Sequential 16x16 shift-and-add multiplier built on one `my_adder_16` instance. It sits directly downstream of the adder, using it as the accumulate stage. It returns the low 16 bits of the product, which wrap like the adder, plus an overflow flag for a nonzero high half. A start/busy/done handshake lets the ALU or CPU sequencer issue one multiply at a time.

## Interface
Parameters:
- none (width fixed at 16 to match `my_adder_16`)

Ports:
- `clk`  input  1  rising-edge clock; the only clock
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  request; sampled only in IDLE
- `a`  input  16  multiplicand (unsigned), captured on the accepting edge
- `b`  input  16  multiplier (unsigned), captured on the accepting edge
- `busy`  output  1  high from the accepting edge until the result is presented
- `done`  output  1  one-cycle pulse; `out` and `overflow` are valid
- `out`  output  16  low 16 bits of a*b; held until the next accepted start
- `overflow`  output  1  high when bits [31:16] of the true product are nonzero

## Operation
- Registers:
  - M[15:0]: multiplicand.
  - P_hi[15:0] and P_lo[15:0]: product and multiplier shift pair.
  - C: carry bit.
  - cnt[4:0]: step counter.
- Accumulate uses one `my_adder_16`: sum = P_hi + M.
  - `my_adder_16` has no carry-out, so carry is derived as c16 = (P_hi[15] & M[15]) | ((P_hi[15] | M[15]) & ~sum[15]).
- States:
  - IDLE:
    - start=1 → latch M=a, P_hi=0, P_lo=b, C=0, cnt=0; go to RUN.
    - start=0 → stay.
  - RUN, one step per clock:
    - if P_lo[0]=1, {C,P_hi} = {c16,sum}; else {C,P_hi} = {0,P_hi}.
    - Then shift {C,P_hi,P_lo} right by 1 in the same edge (C shifts into P_hi[15], P_hi[0] into P_lo[15]).
    - cnt++. After step 16 (cnt was 15), go to DONE and load out=P_lo(final) and overflow=|P_hi(final) on that same edge.
  - DONE: lasts exactly one cycle; go to IDLE unconditionally.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - `out`/`overflow` are registers, updated only on the RUN→DONE edge.
- `start` in RUN or DONE is ignored, with no queueing. `a`/`b` changes after acceptance have no effect.
- `start` held high continuously: a new multiply is accepted in the first IDLE cycle after each DONE.
- Zero operands still take the full 16 steps; there is no early termination.
- Arithmetic is unsigned. The 32-bit product is exact internally, and only the low half is exported.

## Timing
- Reset (asynchronous, takes effect immediately, no clock needed):
  - state=IDLE; busy=0, done=0, out=16'h0000, overflow=0.
  - All internal registers are 0.
- Reset asserted mid-RUN or in DONE aborts the operation. No done pulse is produced for it, and out/overflow return to 0.
- First edge after reset release with start=1 is accepted normally.
- Latency, with start accepted at edge E0:
  - busy=1 after E0.
  - RUN steps occur on E1..E16.
  - After E16: busy=0, done=1, out/overflow valid.
  - After E17: done=0, state IDLE, out/overflow held.
- Throughput: one multiply per 18 cycles (accept + 16 steps + DONE).
- busy and done are never high together. done is never high for more than one cycle.

## Test plan
- a=3, b=5, start pulse → done exactly 17 cycles after the accepting edge; out=16'h000F, overflow=0; busy high for exactly 16 cycles.
- a=16'h00FF, b=16'h0101 → out=16'hFFFF, overflow=0. Then a=16'h4000, b=2 → out=16'h8000, overflow=0.
- a=16'h0100, b=16'h0100 → out=16'h0000, overflow=1. Then a=16'hFFFF, b=16'hFFFF → out=16'h0001, overflow=1 (product 32'hFFFE0001; exercises c16).
- Accept a=7, b=6; pulse start with a=9, b=9 during RUN, and again during DONE → both ignored; out=16'h002A; only one done pulse.
- Accept a=16'h1234, b=16'h0010; assert reset at step 8 → outputs immediately 0, no done. After release, a=2, b=0 → out=0, overflow=0 after 17 cycles.
- start held high with a=10, b=10 for 40 cycles → two done pulses 18 cycles apart, out=16'h0064 each time, overflow=0.
